// File: rtl/event_rr_scheduler.sv
// rtl/event_rr_scheduler.sv - round-robin qualify/start/wait scheduler for a shared event processor
// Requests must stay high for STABLE_CYCLES samples before a start; all outputs come straight from flops.
module event_rr_scheduler #(
    parameter int NUM_CH        = 4,
    parameter int STABLE_CYCLES = 2,
    parameter int TIMEOUT       = 255,
    parameter int CNT_W         = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_CH-1:0]          req_i,
    input  logic                       done_i,
    output logic [NUM_CH-1:0]          grant_o,
    output logic                       start_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o,
    output logic                       abort_o,
    output logic [$clog2(NUM_CH)-1:0]  id_o,
    output logic [NUM_CH*CNT_W-1:0]    count_o
);

    localparam int IDW = $clog2(NUM_CH);
    localparam int QW  = $clog2(STABLE_CYCLES + 1);
    localparam int TW  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_QUAL  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t              state_q;
    logic [IDW-1:0]      sel_q;
    logic [IDW-1:0]      ptr_q;
    logic [QW-1:0]       qual_cnt_q;
    logic [TW-1:0]       timer_q;
    logic [NUM_CH-1:0]   grant_q;
    logic                start_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic                abort_q;
    logic [CNT_W-1:0]    count_q [NUM_CH];

    logic [IDW-1:0]      pick_d;
    logic                pick_vld_d;
    logic [IDW:0]        cand_sum_d;
    logic [IDW-1:0]      next_ptr_d;

    // First requesting channel at or above ptr_q, wrapping past NUM_CH-1.
    always_comb begin
        pick_d     = '0;
        pick_vld_d = 1'b0;
        cand_sum_d = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand_sum_d = {1'b0, ptr_q} + (IDW+1)'(k);
            if (cand_sum_d >= (IDW+1)'(NUM_CH)) begin
                cand_sum_d = cand_sum_d - (IDW+1)'(NUM_CH);
            end
            if (!pick_vld_d && req_i[cand_sum_d[IDW-1:0]]) begin
                pick_d     = cand_sum_d[IDW-1:0];
                pick_vld_d = 1'b1;
            end
        end
    end

    assign next_ptr_d = (sel_q == IDW'(NUM_CH - 1)) ? '0 : sel_q + IDW'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            sel_q      <= '0;
            ptr_q      <= '0;
            qual_cnt_q <= '0;
            timer_q    <= '0;
            grant_q    <= '0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            abort_q    <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                count_q[i] <= '0;
            end
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pick_vld_d) begin
                        sel_q      <= pick_d;
                        qual_cnt_q <= QW'(1);
                        grant_q    <= NUM_CH'(1) << pick_d;
                        busy_q     <= 1'b1;
                        state_q    <= S_QUAL;
                    end
                end
                S_QUAL: begin
                    if (!req_i[sel_q]) begin
                        abort_q <= 1'b1;
                        ptr_q   <= next_ptr_d;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (qual_cnt_q == QW'(STABLE_CYCLES)) begin
                        start_q <= 1'b1;
                        state_q <= S_START;
                    end else begin
                        qual_cnt_q <= qual_cnt_q + QW'(1);
                    end
                end
                S_START: begin
                    timer_q <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // done_i is tested first so it wins over a coincident timeout.
                    if (done_i) begin
                        done_q         <= 1'b1;
                        count_q[sel_q] <= count_q[sel_q] + CNT_W'(1);
                        state_q        <= S_FIN;
                    end else if (timer_q == TW'(TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= S_FIN;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_FIN: begin
                    ptr_q   <= next_ptr_d;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign grant_o = grant_q;
    assign start_o = start_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign abort_o = abort_q;
    assign id_o    = sel_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_count
        assign count_o[g*CNT_W +: CNT_W] = count_q[g];
    end

endmodule

// File: tb/tb_event_rr_scheduler.sv
// tb/tb_event_rr_scheduler.sv - scoreboard bench for event_rr_scheduler
// Expected outcomes are queued when stimulus is driven and retired on each done/err/abort pulse.
module tb_event_rr_scheduler;

    localparam int NC = 4;
    localparam int SC = 2;
    localparam int TO = 4;
    localparam int CW = 4;

    logic            clk;
    logic            rst_i;
    logic [NC-1:0]   req_i;
    logic            done_i;
    logic [NC-1:0]   grant_o;
    logic            start_o;
    logic            busy_o;
    logic            done_o;
    logic            err_o;
    logic            abort_o;
    logic [1:0]      id_o;
    logic [NC*CW-1:0] count_o;

    event_rr_scheduler #(
        .NUM_CH(NC), .STABLE_CYCLES(SC), .TIMEOUT(TO), .CNT_W(CW)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .done_i(done_i),
        .grant_o(grant_o), .start_o(start_o), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o), .abort_o(abort_o),
        .id_o(id_o), .count_o(count_o)
    );

    typedef struct {
        int kind;   // 1 done, 2 err, 3 abort
        int id;
        int cnt;
    } exp_t;

    exp_t sb_q[$];
    int   exp_cnt[NC];
    int   n_vec = 0;
    int   n_err = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int cnt_of(input int ch);
        logic [NC*CW-1:0] v;
        v = count_o >> (ch * CW);
        return int'(v[CW-1:0]);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i  = 1'b1;
        req_i  = '0;
        done_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
        for (int c = 0; c < NC; c++) exp_cnt[c] = 0;
        @(negedge clk);
        check("rst_outputs", {grant_o, start_o, busy_o, done_o, err_o, abort_o, id_o}, 0);
        check("rst_count", count_o, 0);
    endtask

    // Waits for start_o; n counts negedges seen, so calling at posedge+1 of an
    // arbitrating IDLE cycle gives SC+2.
    task automatic wait_start(input int ch, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!start_o && n < 40);
        check("start_seen", start_o, 1);
        check("start_id", id_o, ch);
        check("start_grant", grant_o, 64'(1) << ch);
    endtask

    task automatic run_txn(input int ch, input int dly, input int exp_lat);
        int n;
        wait_start(ch, n);
        if (exp_lat > 0) check("start_latency", n, exp_lat);
        step();
        repeat (dly) step();
        done_i = 1'b1;
        exp_cnt[ch] = (exp_cnt[ch] + 1) % (1 << CW);
        sb_q.push_back('{kind: 1, id: ch, cnt: exp_cnt[ch]});
        step();
        done_i = 1'b0;
        @(negedge clk);
        check("fin_done", done_o, 1);
        check("fin_err", err_o, 0);
        check("fin_grant", grant_o, 64'(1) << ch);
        step();
        check("idle_busy", busy_o, 0);
        check("idle_grant", grant_o, 0);
    endtask

    always @(negedge clk) begin
        int   kind;
        exp_t rec;
        if (done_o || err_o || abort_o) begin
            kind = done_o ? 1 : (err_o ? 2 : 3);
            check("sb_one_pulse", 64'($countones({done_o, err_o, abort_o})), 1);
            if (sb_q.size() == 0) begin
                check("sb_unexpected", kind, 0);
            end else begin
                rec = sb_q.pop_front();
                check("sb_kind", kind, rec.kind);
                check("sb_id", id_o, rec.id);
                check("sb_count", cnt_of(int'(id_o)), rec.cnt);
            end
        end
    end

    initial begin
        int n;
        rst_i  = 1'b1;
        req_i  = '0;
        done_i = 1'b0;

        // Single channel, done two cycles after start.
        do_reset();
        step();
        req_i = 4'b0001;
        run_txn(0, 1, SC + 2);
        req_i = '0;
        check("t1_count0", cnt_of(0), 1);

        // All channels requesting: rotation 0,1,2,3 twice.
        do_reset();
        step();
        req_i = 4'b1111;
        for (int i = 0; i < 8; i++) run_txn(i % NC, 0, SC + 2);
        req_i = '0;
        for (int c = 0; c < NC; c++) check("t2_count", cnt_of(c), 2);

        // One-cycle request on channel 2 aborts; pointer moves to 3.
        do_reset();
        step();
        req_i = 4'b0100;
        step();
        req_i = '0;
        sb_q.push_back('{kind: 3, id: 2, cnt: exp_cnt[2]});
        @(negedge clk);
        check("t3_qual_busy", busy_o, 1);
        check("t3_qual_grant", grant_o, 4'b0100);
        check("t3_qual_abort", abort_o, 0);
        step();
        @(negedge clk);
        check("t3_abort", abort_o, 1);
        check("t3_abort_id", id_o, 2);
        check("t3_no_start", start_o, 0);
        check("t3_abort_busy", busy_o, 0);
        req_i = 4'b0101;
        run_txn(0, 0, SC + 1);
        run_txn(2, 0, SC + 2);
        req_i = '0;

        // Timeout on channel 1, then done coinciding with the timeout edge.
        do_reset();
        step();
        req_i = 4'b0010;
        wait_start(1, n);
        check("t4_start_latency", n, SC + 2);
        sb_q.push_back('{kind: 2, id: 1, cnt: exp_cnt[1]});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!err_o && n < 20);
        check("t4_err_latency", n, TO + 1);
        check("t4_err_no_done", done_o, 0);
        check("t4_err_count", cnt_of(1), 0);
        req_i = '0;
        step();
        step();
        req_i = 4'b0010;
        run_txn(1, TO - 1, SC + 2);
        req_i = '0;
        check("t4_tie_count", cnt_of(1), 1);

        // Counter wrap on channel 1.
        do_reset();
        step();
        req_i = 4'b0010;
        for (int i = 0; i < 16; i++) begin
            run_txn(1, 0, SC + 2);
            if (i == 14) check("t5_count_max", cnt_of(1), 15);
        end
        req_i = '0;
        check("t5_count_wrap", cnt_of(1), 0);

        // Reset during WAIT with done_i asserted in the reset cycle.
        do_reset();
        step();
        req_i = 4'b0001;
        run_txn(0, 0, SC + 2);
        wait_start(0, n);
        step();
        rst_i  = 1'b1;
        done_i = 1'b1;
        step();
        rst_i  = 1'b0;
        done_i = 1'b0;
        req_i  = '0;
        for (int c = 0; c < NC; c++) exp_cnt[c] = 0;
        @(negedge clk);
        check("t6_outputs", {grant_o, start_o, busy_o, done_o, err_o, abort_o, id_o}, 0);
        check("t6_count", count_o, 0);
        step();
        @(negedge clk);
        check("t6_no_pulse", {done_o, err_o, abort_o, busy_o}, 0);

        repeat (3) step();
        check("sb_leftover", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
